// File: rtl/tf_fetch_ctrl.sv
// Twiddle-factor fetch controller.
// Streams NUM_WORDS twiddle words from a registered-read ROM, in ascending or
// descending address order, into a 4-entry FIFO. The FIFO head is presented
// to a consumer as three unpacked lanes under a valid/ready handshake.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; inv is latched when start is accepted
// RUN    | issuing ROM reads whenever the FIFO has room for the result
// DRAIN  | all reads issued; waiting for the consumer to pop the last word
module tf_fetch_ctrl #(
    parameter int DATA_W    = 42,
    parameter int TW_W      = 14,
    parameter int ADDR_W    = 7,
    parameter int NUM_WORDS = 108
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              inv,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ren,
    input  logic [DATA_W-1:0] rom_q,
    output logic [TW_W-1:0]   tw0,
    output logic [TW_W-1:0]   tw1,
    output logic [TW_W-1:0]   tw2,
    output logic              tw_valid,
    input  logic              tw_ready
);

    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_inv;
    logic                r_pend;
    logic [CNT_W-1:0]    r_issued;
    logic [CNT_W-1:0]    r_popped;
    logic [ADDR_W-1:0]   r_next_addr;
    logic [ADDR_W-1:0]   r_last_addr;

    logic [DATA_W-1:0]   r_fifo [4];
    logic [1:0]          r_wr_ptr;
    logic [1:0]          r_rd_ptr;
    logic [2:0]          r_occ;

    logic                w_ren;
    logic                w_done;
    logic                w_valid;
    logic                w_pop;
    logic                w_accept;
    logic [DATA_W-1:0]   w_head;
    logic [ADDR_W-1:0]   w_step_addr;

    assign w_valid  = (r_occ != 3'd0);
    assign w_pop    = w_valid && tw_ready;
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_head   = r_fifo[r_rd_ptr];

    // Pre-computed next address; only consumed when a read actually issues.
    assign w_step_addr = r_inv ? (r_next_addr - ADDR_W'(1)) : (r_next_addr + ADDR_W'(1));

    // Next-state and read-issue decision. The word sitting on rom_q (r_pend)
    // counts against FIFO space; a pop in the same cycle is deliberately not
    // credited so the read decision never depends on tw_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_ren       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_ren = (r_issued < CNT_W'(NUM_WORDS)) &&
                        (({1'b0, r_occ} + {3'b000, r_pend}) < 4'd4);
                if (w_ren && (r_issued == CNT_W'(NUM_WORDS - 1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_popped == CNT_W'(NUM_WORDS - 1))) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run bookkeeping: direction latch, issue/pop counts and the ROM address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inv       <= 1'b0;
            r_pend      <= 1'b0;
            r_issued    <= '0;
            r_popped    <= '0;
            r_next_addr <= '0;
            r_last_addr <= '0;
        end else begin
            r_pend <= w_ren;
            if (w_accept) begin
                r_inv       <= inv;
                r_issued    <= '0;
                r_popped    <= '0;
                r_next_addr <= inv ? ADDR_W'(NUM_WORDS - 1) : '0;
            end else begin
                if (w_ren) begin
                    r_issued    <= r_issued + CNT_W'(1);
                    r_last_addr <= r_next_addr;
                    r_next_addr <= w_step_addr;
                end
                if (w_pop) begin
                    r_popped <= r_popped + CNT_W'(1);
                end
            end
        end
    end

    // FIFO storage; contents are don't-care until written, outputs are gated.
    always_ff @(posedge clk) begin
        if (r_pend) begin
            r_fifo[r_wr_ptr] <= rom_q;
        end
    end

    // FIFO pointers and occupancy; write and pop together leave occ unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_occ    <= 3'd0;
        end else begin
            if (r_pend) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({r_pend, w_pop})
                2'b10:   r_occ <= r_occ + 3'd1;
                2'b01:   r_occ <= r_occ - 3'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // While reading, show the address being issued; otherwise hold the last one.
    assign rom_addr = w_ren ? r_next_addr : r_last_addr;
    assign rom_ren  = w_ren;
    assign busy     = (r_state != S_IDLE);
    assign done     = w_done;
    assign tw_valid = w_valid;
    assign tw0      = w_valid ? w_head[DATA_W-1 -: TW_W]   : '0;
    assign tw1      = w_valid ? w_head[2*TW_W-1 -: TW_W]   : '0;
    assign tw2      = w_valid ? w_head[TW_W-1 -: TW_W]     : '0;

endmodule

// File: doc/tf_fetch_ctrl.md
TF_FETCH_CTRL -- requirements
Module: tf_fetch_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 42, ROM word width.
REQ-002 SHALL have parameter TW_W, default 14, width of one twiddle lane (DATA_W = 3*TW_W).
REQ-003 SHALL have parameter ADDR_W, default 7, ROM address width.
REQ-004 SHALL have parameter NUM_WORDS, default 108, words fetched per run.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a run.
REQ-008 SHALL have port inv, input, 1, sampled with start; 0 = ascending addresses, 1 = descending.
REQ-009 SHALL have port busy, output, 1, run in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at run end.
REQ-011 SHALL have port rom_addr, output, ADDR_W, twiddle ROM address.
REQ-012 SHALL have port rom_ren, output, 1, twiddle ROM read enable.
REQ-013 SHALL have port rom_q, input, DATA_W, ROM data, valid the cycle after rom_ren.
REQ-014 SHALL have ports tw0, tw1, tw2, output, TW_W each, unpacked twiddles.
REQ-015 SHALL have port tw_valid, output, 1; and tw_ready, input, 1; consumer handshake.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-017 IDLE: start=1 latches inv; next state RUN; busy=1 from the following cycle.
REQ-018 start while busy=1 SHALL be ignored; inv SHALL NOT be resampled mid-run.
REQ-019 ROM model fixed: rom_ren in cycle n, rom_q valid in cycle n+1 only, written into output FIFO at end of cycle n+1.
REQ-020 pend SHALL be registered copy of rom_ren (1 while a word sits on rom_q).
REQ-021 Output FIFO SHALL be 4 entries of DATA_W; occ = current occupancy 0..4.
REQ-022 RUN: rom_ren=1 iff issued < NUM_WORDS and occ + pend < 4; pop not credited.
REQ-023 Address sequence SHALL be 0,1,...,NUM_WORDS-1 for inv=0; NUM_WORDS-1 down to 0 for inv=1; one step per asserted rom_ren.
REQ-024 rom_addr SHALL hold its last value while rom_ren=0.
REQ-025 RUN -> DRAIN when the last (NUM_WORDS-th) read issues.
REQ-026 tw_valid = (occ != 0); transfer when tw_valid and tw_ready both 1.
REQ-027 tw0 = head[41:28], tw1 = head[27:14], tw2 = head[13:0] (generally lanes MSB-first); stable while tw_valid=1 and tw_ready=0.
REQ-028 Simultaneous FIFO write and pop SHALL leave occ unchanged; never overflow or underflow.
REQ-029 DRAIN -> IDLE when NUM_WORDS words popped; done=1 in that transition cycle, busy=0 next cycle.
REQ-030 Minimum latency: start at cycle 0 -> rom_ren cycle 1 -> tw_valid cycle 3; throughput 1 word/cycle with tw_ready held 1.
REQ-031 Counters SHALL be sized for NUM_WORDS with no wrap within a run.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, occ=0, pend=0, issued/popped counts=0, rom_addr=0, rom_ren=0, busy=0, done=0, tw_valid=0, tw0/tw1/tw2=0.
REQ-033 rst asserted mid-run SHALL abort the run; words in FIFO and on rom_q discarded; no done pulse.
REQ-034 After rst release, first start SHALL behave as from power-up.

Verification (bench ROM: registered read, word = {addr,addr,addr} in 14-bit lanes)
REQ-035 inv=0, start cycle 0, tw_ready=1 -> rom_ren cycles 1..108, tw_valid cycles 3..110 with tw0=tw1=tw2=0,1,...,107, done pulse cycle 110.
REQ-036 inv=1, tw_ready=1 -> tw0 sequence 107 down to 0, rom_addr starts 107, ends 0; done once.
REQ-037 tw_ready=0 for cycles 3..20 -> occ peaks at 4, rom_ren stalls, no word lost or duplicated, outputs stable; full order recovered after release.
REQ-038 Random tw_ready (50%) -> exactly 108 transfers in order, done after last transfer, occ never >4.
REQ-039 start pulsed again at cycle 50 of a run -> ignored, sequence unaffected; rst at cycle 40 -> all outputs 0 same cycle, new run after release starts at address 0.
